// File: rtl/int_mac_dot_seq.sv
// -----------------------------------------------------------------------------
// int_mac_dot_seq
//   Sequential unsigned integer dot-product engine. A job is started with a
//   vector length, then operand pairs are streamed in over a valid/ready
//   handshake. Each accepted pair is registered into an operand stage and
//   multiplied/accumulated on the following edge. Products and sums wrap
//   modulo 2^DATA_PATH_BITWIDTH. The result is then offered with a
//   valid/ready handshake.
//
// Ports
//   clk        in   clock, rising-edge active
//   rst        in   asynchronous reset, active low
//   start      in   begin a job (only looked at while idle)
//   clear      in   synchronous abort back to idle, highest priority
//   len        in   element count, captured with an accepted start
//   in_valid   in   operand pair a/b is valid
//   in_ready   out  engine accepts an operand pair this cycle
//   a, b       in   unsigned operands
//   out_valid  out  result is valid
//   out_ready  in   consumer takes the result
//   result     out  accumulated dot product (meaningful while out_valid)
//   busy       out  engine is not idle
// -----------------------------------------------------------------------------
module int_mac_dot_seq #(
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int LEN_BITWIDTH       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          clear,
  input  logic [LEN_BITWIDTH-1:0]       len,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] a,
  input  logic [DATA_PATH_BITWIDTH-1:0] b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_PATH_BITWIDTH-1:0] result,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [LEN_BITWIDTH-1:0]       count_reg;
  logic [DATA_PATH_BITWIDTH-1:0] acc_reg;
  logic [DATA_PATH_BITWIDTH-1:0] a_reg;
  logic [DATA_PATH_BITWIDTH-1:0] b_reg;
  logic                          op_valid_reg;

  logic                          beat;
  logic                          start_accept;
  logic [DATA_PATH_BITWIDTH-1:0] product;

  assign beat         = in_valid & in_ready;
  assign start_accept = (state_reg == IDLE) & start;
  // Same-width multiply: the upper half of the product is discarded, which
  // is exactly the modulo wrap the accumulator needs.
  assign product      = a_reg * b_reg;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else if (clear) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // The beat that consumes the last element moves on; its product is
        // still sitting in the operand stage and is folded in during DRAIN.
        if (beat && (count_reg == LEN_BITWIDTH'(1))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_reg)
      IDLE:    busy      = 1'b0;
      RUN:     in_ready  = 1'b1;
      DRAIN:   ;
      DONE:    out_valid = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  assign result = acc_reg;

  // ---------------------------------------------------------------------------
  // Datapath: remaining count, operand stage, accumulator
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg    <= '0;
      acc_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_valid_reg <= 1'b0;
    end else if (clear) begin
      count_reg    <= '0;
      acc_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_valid_reg <= 1'b0;
    end else begin
      // The operand stage holds the pair accepted on the previous edge; the
      // flag keeps bubble cycles from re-adding a stale product.
      if (op_valid_reg) begin
        acc_reg <= acc_reg + product;
      end
      op_valid_reg <= beat;
      if (beat) begin
        a_reg     <= a;
        b_reg     <= b;
        count_reg <= count_reg - LEN_BITWIDTH'(1);
      end
      // op_valid_reg is always low in IDLE, so this cannot collide with an
      // accumulate above.
      if (start_accept) begin
        count_reg <= len;
        acc_reg   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_int_mac_dot_seq.sv
// -----------------------------------------------------------------------------
// tb_int_mac_dot_seq
//   Self-checking bench for int_mac_dot_seq. Inputs are driven and outputs
//   sampled on the falling edge; the DUT acts on the rising edge. Expected
//   results come from a plain arithmetic dot product truncated to 16 bits.
// -----------------------------------------------------------------------------
module tb_int_mac_dot_seq;

  localparam int DW = 16;
  localparam int LW = 8;
  localparam int MAXN = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic          clear;
  logic [LW-1:0] len;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          busy;

  int n_checks;
  int n_pass;

  logic [DW-1:0] va [0:MAXN-1];
  logic [DW-1:0] vb [0:MAXN-1];

  int_mac_dot_seq #(
    .DATA_PATH_BITWIDTH (DW),
    .LEN_BITWIDTH       (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .clear     (clear),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the dot product of the first n elements, wrapped to DW bits.
  function automatic logic [DW-1:0] model_dot(input int n);
    logic [63:0] sum;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      sum = sum + 64'(va[i]) * 64'(vb[i]);
    end
    return sum[DW-1:0];
  endfunction

  // Runs one complete job from idle. Called at a falling edge, returns at a
  // falling edge with the engine idle again.
  task automatic run_job(input int n, input int bubble_pct, input int hold, input bit poke_start);
    logic [DW-1:0] exp_res;
    int idx;
    int guard;
    exp_res = model_dot(n);
    start = 1'b1;
    len   = LW'(n);
    @(negedge clk);
    start = 1'b0;
    len   = LW'($urandom_range(255));
    idx   = 0;
    guard = 0;
    while (idx < n && guard < 1000) begin
      check("in_ready_run", {31'd0, in_ready}, 32'd1);
      if ($urandom_range(99) < bubble_pct) begin
        in_valid = 1'b0;
        a        = DW'($urandom);
        b        = DW'($urandom);
      end else begin
        in_valid = 1'b1;
        a        = va[idx];
        b        = vb[idx];
      end
      // A start during RUN must be ignored.
      if (poke_start) start = 1'($urandom_range(1));
      @(posedge clk);
      if (in_valid) idx++;
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      guard++;
    end
    if (guard >= 1000) check("run_timeout", 32'(idx), 32'(n));
    if (n > 0) begin
      // One cycle after the last beat edge: the final product is still being
      // folded in, so nothing is offered yet.
      check("drain_out_valid", {31'd0, out_valid}, 32'd0);
      check("drain_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    for (int h = 0; h < hold; h++) begin
      check("done_hold_valid", {31'd0, out_valid}, 32'd1);
      check("done_hold_result", 32'(result), 32'(exp_res));
      @(negedge clk);
    end
    check("done_out_valid", {31'd0, out_valid}, 32'd1);
    check("done_in_ready", {31'd0, in_ready}, 32'd0);
    check("done_result", 32'(result), 32'(exp_res));
    $display("job len=%0d bubbles=%0d%% hold=%0d result=0x%04h expected=0x%04h",
             n, bubble_pct, hold, result, exp_res);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("after_out_valid", {31'd0, out_valid}, 32'd0);
    check("after_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b0;
    start     = 1'b0;
    clear     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;

    // Reset state.
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed: {2,3,4}.{5,6,7} back to back = 56.
    va[0] = 2; va[1] = 3; va[2] = 4;
    vb[0] = 5; vb[1] = 6; vb[2] = 7;
    run_job(3, 0, 0, 1'b0);
    check("dot_56", 32'(model_dot(3)), 32'd56);

    // Zero length goes straight to DONE with 0.
    run_job(0, 0, 0, 1'b0);

    // Wrap: 0xFFFF * 0xFFFF mod 2^16 = 1.
    va[0] = 16'hFFFF; vb[0] = 16'hFFFF;
    run_job(1, 0, 0, 1'b0);

    // Four ones with bubbles and a slow consumer.
    for (int i = 0; i < 4; i++) begin va[i] = 1; vb[i] = 1; end
    run_job(4, 50, 5, 1'b0);

    // Clear mid-job, with a start pulse during RUN, then a fresh job.
    start = 1'b1;
    len   = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a        = 16'd7;
      b        = 16'd9;
      start    = 1'b1;
      len      = 8'd1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    @(negedge clk);
    check("pre_clear_busy", {31'd0, busy}, 32'd1);
    check("pre_clear_in_ready", {31'd0, in_ready}, 32'd1);
    clear    = 1'b1;
    in_valid = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    start    = 1'b0;
    check("clear_busy", {31'd0, busy}, 32'd0);
    check("clear_result", 32'(result), 32'd0);
    check("clear_in_ready", {31'd0, in_ready}, 32'd0);
    va[0] = 3; vb[0] = 3;
    run_job(1, 0, 0, 1'b0);

    // Asynchronous reset in the middle of a job.
    for (int i = 0; i < 4; i++) begin va[i] = 16'd5; vb[i] = 16'd5; end
    start = 1'b1;
    len   = 8'd4;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    a        = 16'd5;
    b        = 16'd5;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b0;

    // Randomised jobs.
    for (int j = 0; j < 40; j++) begin
      int n;
      n = $urandom_range(MAXN - 1);
      for (int i = 0; i < MAXN; i++) begin
        va[i] = DW'($urandom);
        vb[i] = DW'($urandom);
      end
      run_job(n, $urandom_range(60), $urandom_range(3), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
